sweep_pulse_driver: RTL and testbench

Consumer end of the sweep mask/frequency-select interface. It latches the per-bit level selections published by the sweep generator and drives one PWM pulse output per mask bit. It also generates the tick strobe that paces the sweep generator, which closes the loop. It sits between the sweep generator and the pad/LED drivers.

---
 rtl/pulse_gen_pkg.sv | 34 +++
 rtl/sweep_pulse_driver_pwm_channel.sv | 64 ++++++
 rtl/sweep_pulse_driver.sv | 100 ++++++++++
 tb/tb_sweep_pulse_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared helpers for the sweep generator / pulse driver pair.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
//
// Contents:
//   sel_width_f : bits needed to hold a level 0..steps
//   cnt_width_f : bits for a 0..n-1 counter, never less than one
//   sat_level   : clamp a requested level to the top level
//   field_lsb   : LSB of packed field idx when each field is fw bits wide
package pulse_gen_pkg;

    localparam int unsigned MIN_CNT_WIDTH = 1;

    function automatic int unsigned sel_width_f(input int unsigned steps);
        return $clog2(steps + 1);
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < MIN_CNT_WIDTH) ? MIN_CNT_WIDTH : w;
    endfunction

    function automatic int unsigned sat_level(input int unsigned lvl,
                                              input int unsigned max_lvl);
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

    function automatic int unsigned field_lsb(input int unsigned idx,
                                              input int unsigned fw);
        return idx * fw;
    endfunction

endpackage

// File: rtl/sweep_pulse_driver_pwm_channel.sv
// One PWM channel: shadow/active level pair plus duty comparator.
// Latency: pulse is registered, one cycle behind the shared pwm counter.
// Backpressure: none; a new selection simply overwrites the shadow level.
//
// Ports:
//   clk_i      clock
//   clr        synchronous clear (reset or enable low), wins over set
//   set        new selection strobe
//   frame_end  last cycle of the current PWM frame
//   pending    a shadow level is waiting to be promoted
//   mask       channel enable bit from the sweep generator
//   sel        requested level for this channel (saturated here)
//   pwm_cnt    shared PWM step counter
//   pulse      registered PWM output
module pwm_channel
    import pulse_gen_pkg::*;
#(
    parameter int FREQ_STEPS = 4,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                 clk_i,
    input  logic                 clr,
    input  logic                 set,
    input  logic                 frame_end,
    input  logic                 pending,
    input  logic                 mask,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic [SEL_WIDTH-1:0] pwm_cnt,
    output logic                 pulse
);

    logic [SEL_WIDTH-1:0] new_lvl;
    logic [SEL_WIDTH-1:0] shadow;
    logic [SEL_WIDTH-1:0] active;

    // Masked-off channels capture level 0, i.e. a constantly low output.
    always_comb begin
        new_lvl = '0;
        if (mask) begin
            new_lvl = SEL_WIDTH'(sat_level(32'(sel), FREQ_STEPS));
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            shadow <= '0;
            active <= '0;
            pulse  <= 1'b0;
        end else begin
            // Level FREQ_STEPS exceeds every counter value -> high all frame.
            pulse <= (pwm_cnt < active);
            if (set && frame_end) begin
                // Coincident update: take the newest data immediately.
                active <= new_lvl;
                shadow <= new_lvl;
            end else if (set) begin
                shadow <= new_lvl;
            end else if (frame_end && pending) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/sweep_pulse_driver.sv
// Latches sweep-generator level selections and drives one PWM pulse per mask bit; paces the generator with tick_o.
// Latency: pulse_o is one cycle behind the PWM counter; new levels take effect at the next frame boundary.
// Backpressure: none; set_i is always accepted, a second set_i before the frame boundary replaces the first.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   en_i      operation enable; low behaves as reset on the next edge
//   mask_i    per-channel mask from the sweep generator
//   set_i     one-cycle strobe: mask_i/select_i are valid
//   select_i  packed per-channel levels, channel j at [j*SEL_WIDTH +: SEL_WIDTH]
//   tick_o    one-cycle pace strobe every TICK_FRAMES frames
//   pulse_o   registered PWM outputs
//   pending_o a shadow selection awaits the next frame boundary
module sweep_pulse_driver
    import pulse_gen_pkg::*;
#(
    parameter  int WIDTH       = 4,
    parameter  int FREQ_STEPS  = 4,
    parameter  int PRESCALE    = 2,
    parameter  int TICK_FRAMES = 1,
    localparam int SEL_WIDTH   = sel_width_f(FREQ_STEPS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [WIDTH-1:0]           mask_i,
    input  logic                       set_i,
    input  logic [SEL_WIDTH*WIDTH-1:0] select_i,
    output logic                       tick_o,
    output logic [WIDTH-1:0]           pulse_o,
    output logic                       pending_o
);

    localparam int PRE_W = cnt_width_f(PRESCALE);
    localparam int FRM_W = cnt_width_f(TICK_FRAMES);

    logic [PRE_W-1:0]     pre_cnt;
    logic [SEL_WIDTH-1:0] pwm_cnt;
    logic [FRM_W-1:0]     frm_cnt;
    logic                 pending;
    logic                 clr;
    logic                 step;
    logic                 frame_end;

    // Dropping the enable clears everything exactly like reset, ahead of set_i.
    assign clr       = rst_i | ~en_i;
    assign step      = en_i & (pre_cnt == PRE_W'(PRESCALE - 1));
    assign frame_end = step & (pwm_cnt == SEL_WIDTH'(FREQ_STEPS - 1));
    assign pending_o = pending;

    always_ff @(posedge clk_i) begin
        if (clr) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            frm_cnt <= '0;
            pending <= 1'b0;
            tick_o  <= 1'b0;
        end else begin
            pre_cnt <= step ? '0 : pre_cnt + PRE_W'(1);

            if (step) begin
                pwm_cnt <= (pwm_cnt == SEL_WIDTH'(FREQ_STEPS - 1)) ?
                           '0 : pwm_cnt + SEL_WIDTH'(1);
            end

            if (frame_end) begin
                frm_cnt <= (frm_cnt == FRM_W'(TICK_FRAMES - 1)) ?
                           '0 : frm_cnt + FRM_W'(1);
            end

            tick_o <= frame_end & (frm_cnt == FRM_W'(TICK_FRAMES - 1));

            // A set landing on the boundary is applied directly, so nothing waits.
            if (set_i && !frame_end) begin
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_ch
        pwm_channel #(
            .FREQ_STEPS (FREQ_STEPS),
            .SEL_WIDTH  (SEL_WIDTH)
        ) u_ch (
            .clk_i     (clk_i),
            .clr       (clr),
            .set       (set_i),
            .frame_end (frame_end),
            .pending   (pending),
            .mask      (mask_i[j]),
            .sel       (select_i[field_lsb(j, SEL_WIDTH) +: SEL_WIDTH]),
            .pwm_cnt   (pwm_cnt),
            .pulse     (pulse_o[j])
        );
    end

endmodule

// File: tb/tb_sweep_pulse_driver.sv
// Directed bench for sweep_pulse_driver: default instance (frame = 8 cycles)
// plus a TICK_FRAMES=3 instance for tick pacing.
module tb_sweep_pulse_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        rst, en, set;
    logic [3:0]  mask;
    logic [11:0] sel;
    logic        tick, pending;
    logic [3:0]  pulse;

    // TICK_FRAMES = 3 instance
    logic        rst2, en2, set2;
    logic [3:0]  mask2;
    logic [11:0] sel2;
    logic        tick2, pending2;
    logic [3:0]  pulse2;

    int tests = 0;
    int fails = 0;
    int cnt [4];

    sweep_pulse_driver dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .mask_i(mask), .set_i(set),
        .select_i(sel), .tick_o(tick), .pulse_o(pulse), .pending_o(pending)
    );

    sweep_pulse_driver #(.TICK_FRAMES(3)) dut3 (
        .clk_i(clk), .rst_i(rst2), .en_i(en2), .mask_i(mask2), .set_i(set2),
        .select_i(sel2), .tick_o(tick2), .pulse_o(pulse2), .pending_o(pending2)
    );

    // Levels packed {ch3, ch2, ch1, ch0}, 3 bits each
    localparam logic [11:0] S1 = {3'd1, 3'd0, 3'd3, 3'd4};
    localparam logic [11:0] S2 = {3'd1, 3'd0, 3'd3, 3'd2};
    localparam logic [11:0] S3 = {3'd1, 3'd0, 3'd3, 3'd7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) cnt[j] += int'(pulse[j]);
    endtask

    task automatic clr_cnt();
        for (int j = 0; j < 4; j++) cnt[j] = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; set = 1'b0; mask = 4'hF; sel = S1;
        rst2 = 1'b1; en2 = 1'b1; set2 = 1'b0; mask2 = 4'h0; sel2 = '0;
        clr_cnt();

        // 1. Reset holds everything low even with set pulsing
        for (int k = 0; k < 6; k++) begin
            set = k[0];
            cyc();
            check("rst_pulse", pulse, 0);
            check("rst_tick", tick, 0);
            check("rst_pending", pending, 0);
        end
        rst = 1'b0; set = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("first_tick", tick, (k == 8));
        end

        // 2. Duty: set mid-frame at cycle 8, applied at cycle 16
        set = 1'b1; mask = 4'hF; sel = S1;
        cyc();                              // E9
        set = 1'b0;
        for (int k = 9; k <= 15; k++) begin
            check("pending_hold", pending, 1);
            if (k < 15) cyc();
        end
        cyc();                              // E16
        check("pending_clear", pending, 0);
        clr_cnt();
        repeat (7) cyc();                   // E17..E23
        // 4. Coincident set during the frame_end cycle (cycle 23)
        set = 1'b1; sel = S2;
        cyc();                              // E24
        set = 1'b0;
        check("duty_ch0", cnt[0], 8);
        check("duty_ch1", cnt[1], 6);
        check("duty_ch2", cnt[2], 0);
        check("duty_ch3", cnt[3], 2);
        check("coinc_pending", pending, 0);
        clr_cnt();
        repeat (8) cyc();                   // E25..E32
        check("coinc_ch0", cnt[0], 4);
        check("coinc_ch1", cnt[1], 6);
        check("coinc_pending_end", pending, 0);

        // 3. Saturation: ch0 requests 7 -> clamped to full duty
        set = 1'b1; sel = S3; mask = 4'hF;
        cyc();                              // E33
        set = 1'b0;
        check("sat_pending", pending, 1);
        repeat (7) cyc();                   // E40
        clr_cnt();
        repeat (8) cyc();                   // E41..E48
        check("sat_ch0", cnt[0], 8);
        check("sat_ch1", cnt[1], 6);
        // Same request with ch0 masked off
        set = 1'b1; sel = S3; mask = 4'hE;
        cyc();                              // E49
        set = 1'b0;
        repeat (7) cyc();                   // E56
        clr_cnt();
        repeat (8) cyc();                   // E57..E64
        check("mask_ch0", cnt[0], 0);
        check("mask_ch1", cnt[1], 6);
        check("mask_ch3", cnt[3], 2);

        // 6. Disable mid-frame with a selection pending
        set = 1'b1; sel = S1; mask = 4'hF;
        cyc();                              // E65
        set = 1'b0;
        cyc();                              // E66
        cyc();                              // E67, reflects cycle 66 (pwm step 1)
        check("pre_dis_pulse", pulse, 4'b0010);
        check("pre_dis_pending", pending, 1);
        en = 1'b0;
        cyc();                              // E68
        check("dis_pulse", pulse, 0);
        check("dis_pending", pending, 0);
        check("dis_tick", tick, 0);
        en = 1'b1;
        clr_cnt();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("reen_tick", tick, (k == 8));
        end
        repeat (8) cyc();
        check("reen_levels", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        check("reen_pending", pending, 0);

        // 5. Tick pacing with TICK_FRAMES=3: one tick per 24 cycles
        rst2 = 1'b0;
        for (int k = 1; k <= 240; k++) begin
            @(posedge clk);
            #1;
            check("tick3", tick2, ((k % 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
